// File: rtl/readout_tx_pkg.sv
// Shared definitions for the readout TX instruction sequencer.
//   - instruction field positions within the 32-bit instruction word
//   - opcode values
//   - sequencer state encoding
package readout_tx_pkg;

  localparam int OP_LSB   = 28;
  localparam int OP_WIDTH = 4;
  localparam int IMM_LSB  = 12;
  localparam int RSVD_BIT = 11;

  localparam logic [OP_WIDTH-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_PLAY = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_WAIT = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_LOOP = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_JUMP = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_HALT = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PLAY   = 3'd4,
    ST_HALTED = 3'd5
  } seq_state_e;

endpackage

// File: rtl/readout_tx_seq_decode.sv
// Combinational instruction field split for the readout TX sequencer.
// Ports:
//   inst  - instruction word from the instruction memory
//   op    - opcode field
//   imm   - immediate field (pulse id / wait length / loop count)
//   tgt   - branch target address
//   legal - opcode is one of NOP, PLAY, WAIT, LOOP, JUMP, HALT
module readout_tx_seq_decode
  import readout_tx_pkg::*;
#(
  parameter int PC_WIDTH   = 11,
  parameter int INST_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic [INST_WIDTH-1:0] inst,
  output logic [OP_WIDTH-1:0]   op,
  output logic [CNT_WIDTH-1:0]  imm,
  output logic [PC_WIDTH-1:0]   tgt,
  output logic                  legal
);

  // Bit 11 is reserved in the encoding and carries no meaning.
  logic unused_rsvd;

  assign op          = inst[OP_LSB +: OP_WIDTH];
  assign imm         = inst[IMM_LSB +: CNT_WIDTH];
  assign tgt         = inst[PC_WIDTH-1:0];
  assign legal       = (op <= OP_HALT);
  assign unused_rsvd = inst[RSVD_BIT];

endmodule

// File: rtl/readout_tx_sequencer.sv
// Readout TX instruction sequencer.
// Fetches from the instruction memory addressed by the external PC register,
// decodes PLAY/WAIT/LOOP/JUMP/HALT and requests pulses from the TX pulse
// generator over a valid/ready handshake.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start, stop  - host control; stop wins over start
//   start_pc     - entry address loaded on start
//   pc, inst     - PC register value and synchronous-read memory data
//   update_pc    - load strobe to the PC register (same-cycle, so a pulse
//                  handshake advances the PC in the ready cycle itself)
//   next_pc      - value loaded when update_pc=1
//   pulse_valid, pulse_id, pulse_ready - pulse request handshake
//   busy, halted, error - status
module readout_tx_sequencer
  import readout_tx_pkg::*;
#(
  parameter int PC_WIDTH   = 11,
  parameter int INST_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PC_WIDTH-1:0]   start_pc,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [INST_WIDTH-1:0] inst,
  output logic                  update_pc,
  output logic [PC_WIDTH-1:0]   next_pc,
  output logic                  pulse_valid,
  output logic [CNT_WIDTH-1:0]  pulse_id,
  input  logic                  pulse_ready,
  output logic                  busy,
  output logic                  halted,
  output logic                  error
);

  seq_state_e           state_q, state_d;
  logic                 pulse_valid_q, pulse_valid_d;
  logic [CNT_WIDTH-1:0] pulse_id_q, pulse_id_d;
  logic                 busy_q, busy_d;
  logic                 halted_q, halted_d;
  logic                 error_q, error_d;
  logic [CNT_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
  logic                 loop_armed_q, loop_armed_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  logic [OP_WIDTH-1:0]  op;
  logic [CNT_WIDTH-1:0] imm;
  logic [PC_WIDTH-1:0]  tgt;
  logic                 legal;

  logic                 update_pc_c;
  logic [PC_WIDTH-1:0]  next_pc_c;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic [CNT_WIDTH-1:0] eff_cnt;

  readout_tx_seq_decode #(
    .PC_WIDTH  (PC_WIDTH),
    .INST_WIDTH(INST_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_decode (
    .inst (inst),
    .op   (op),
    .imm  (imm),
    .tgt  (tgt),
    .legal(legal)
  );

  // Natural wrap modulo 2^PC_WIDTH.
  assign pc_inc  = pc + PC_WIDTH'(1);
  // First encounter of a LOOP uses its immediate; later passes use the counter.
  assign eff_cnt = loop_armed_q ? loop_cnt_q : imm;

  always_comb begin
    state_d       = state_q;
    pulse_valid_d = pulse_valid_q;
    pulse_id_d    = pulse_id_q;
    error_d       = error_q;
    loop_cnt_d    = loop_cnt_q;
    loop_armed_d  = loop_armed_q;
    wait_cnt_d    = wait_cnt_q;
    update_pc_c   = 1'b0;
    next_pc_c     = pc_inc;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        next_pc_c = '0;
        if (start) begin
          update_pc_c  = 1'b1;
          next_pc_c    = start_pc;
          error_d      = 1'b0;
          loop_armed_d = 1'b0;
          loop_cnt_d   = '0;
          state_d      = ST_FETCH;
        end
      end

      ST_FETCH: begin
        next_pc_c = '0;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        if (!legal) begin
          error_d = 1'b1;
          state_d = ST_HALTED;
        end else begin
          case (op)
            OP_NOP: begin
              update_pc_c = 1'b1;
              state_d     = ST_FETCH;
            end
            OP_PLAY: begin
              pulse_valid_d = 1'b1;
              pulse_id_d    = imm;
              state_d       = ST_PLAY;
            end
            OP_WAIT: begin
              if (imm == '0) begin
                update_pc_c = 1'b1;
                state_d     = ST_FETCH;
              end else begin
                wait_cnt_d = imm - CNT_WIDTH'(1);
                state_d    = ST_WAIT;
              end
            end
            OP_LOOP: begin
              update_pc_c = 1'b1;
              state_d     = ST_FETCH;
              if (eff_cnt != '0) begin
                loop_cnt_d   = eff_cnt - CNT_WIDTH'(1);
                loop_armed_d = 1'b1;
                next_pc_c    = tgt;
              end else begin
                loop_cnt_d   = '0;
                loop_armed_d = 1'b0;
              end
            end
            OP_JUMP: begin
              update_pc_c = 1'b1;
              next_pc_c   = tgt;
              state_d     = ST_FETCH;
            end
            OP_HALT: begin
              state_d = ST_HALTED;
            end
            default: begin
              error_d = 1'b1;
              state_d = ST_HALTED;
            end
          endcase
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          update_pc_c = 1'b1;
          state_d     = ST_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_WIDTH'(1);
        end
      end

      ST_PLAY: begin
        if (pulse_ready) begin
          update_pc_c   = 1'b1;
          pulse_valid_d = 1'b0;
          state_d       = ST_FETCH;
        end
      end

      default: begin
        next_pc_c = '0;
        state_d   = ST_IDLE;
      end
    endcase

    // Abort leaves the PC register untouched and keeps the error flag.
    if (stop) begin
      update_pc_c   = 1'b0;
      pulse_valid_d = 1'b0;
      state_d       = ST_IDLE;
    end

    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pulse_valid_q <= 1'b0;
      pulse_id_q    <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      error_q       <= 1'b0;
      loop_cnt_q    <= '0;
      loop_armed_q  <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pulse_valid_q <= pulse_valid_d;
      pulse_id_q    <= pulse_id_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      error_q       <= error_d;
      loop_cnt_q    <= loop_cnt_d;
      loop_armed_q  <= loop_armed_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Strobe is suppressed while reset is held so the PC register never moves.
  assign update_pc   = update_pc_c & ~rst;
  assign next_pc     = rst ? '0 : next_pc_c;
  assign pulse_valid = pulse_valid_q;
  assign pulse_id    = pulse_id_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign error       = error_q;

endmodule

// File: doc/readout_tx_sequencer.md
Name: readout_tx_sequencer

Overview:
Instruction sequencer for the readout TX path. It fetches instructions from the readout TX instruction memory at the address held in the PC register, and drives that register's update_pc / next_PC controls. It decodes PLAY, WAIT, LOOP, JUMP and HALT, and issues pulse requests to the TX pulse generator over a valid/ready handshake. It sits between the host start/stop control and the PC register plus instruction memory.

Parameters:
PC_WIDTH, 11, PC / instruction-memory address width
INST_WIDTH, 32, instruction word width
CNT_WIDTH, 16, immediate field width; also WAIT timer and loop counter width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin execution at start_pc (honoured only in IDLE or HALTED)
stop  in  1  abort execution; return to IDLE
start_pc  in  PC_WIDTH  entry address
pc  in  PC_WIDTH  current PC-register value
inst  in  INST_WIDTH  instruction-memory read data; valid 1 cycle after pc changes (synchronous read)
update_pc  out  1  one-cycle strobe to the PC register
next_pc  out  PC_WIDTH  value the PC register loads when update_pc=1
pulse_valid  out  1  pulse request valid
pulse_id  out  CNT_WIDTH  pulse descriptor index
pulse_ready  in  1  pulse generator accepts the request
busy  out  1  high in every state except IDLE and HALTED
halted  out  1  high in HALTED
error  out  1  sticky illegal-opcode flag; cleared by rst or start

Behaviour:
- Reset: rst is synchronous and active-high. Reset values: state=IDLE; update_pc=0, next_pc=0, pulse_valid=0, pulse_id=0, busy=0, halted=0, error=0; loop_cnt=0, loop_armed=0, wait_cnt=0.
- Encoding: op=inst[31:28]; imm=inst[27:12] (CNT_WIDTH); tgt=inst[PC_WIDTH-1:0]; inst[11] reserved.
- Opcodes: 0 NOP, 1 PLAY, 2 WAIT, 3 LOOP, 4 JUMP, 5 HALT; all others are illegal.
- States: IDLE, FETCH, EXEC, WAIT, PLAY, HALTED.
- IDLE/HALTED, start=1: update_pc=1, next_pc=start_pc; clear error, loop_armed and loop_cnt; go to FETCH.
- FETCH: one bubble cycle for memory latency. update_pc=0. Go to EXEC.
- EXEC (inst valid). Default next_pc = pc+1, wrapping modulo 2^PC_WIDTH (pc=all-ones gives 0).
  - NOP: update_pc=1 → FETCH.
  - PLAY: pulse_valid=1, pulse_id=imm → PLAY.
  - WAIT: if imm=0, behaves as NOP. Otherwise wait_cnt=imm-1 → WAIT.
  - LOOP: if loop_armed=0, set loop_cnt=imm and loop_armed=1. Then evaluate with the effective count (imm on first arm, loop_cnt after): if nonzero, decrement, update_pc=1, next_pc=tgt; if zero, loop_armed=0, update_pc=1, next_pc=pc+1. A LOOP with imm=N executes its body N+1 times total.
  - JUMP: update_pc=1, next_pc=tgt → FETCH.
  - HALT: no update_pc → HALTED.
  - Illegal opcode: error=1, no update_pc → HALTED.
- WAIT: decrement wait_cnt each cycle. In the cycle wait_cnt=0, update_pc=1, next_pc=pc+1 → FETCH. WAIT imm=N occupies N cycles after EXEC.
- PLAY: hold pulse_valid and pulse_id stable until pulse_ready=1. In the handshake cycle, update_pc=1, next_pc=pc+1, then pulse_valid=0 next cycle → FETCH. If pulse_ready is already high in the EXEC cycle, it is not sampled; the handshake completes at the earliest in the first PLAY-state cycle.
- Only one loop level exists; nested LOOPs share loop_cnt.
- stop=1 in any state: go to IDLE next cycle. pulse_valid drops, update_pc=0, PC is not touched, error is held.
- Priority: rst > stop > start.
- start while busy: ignored.
- Reset mid-operation: aborts a pending pulse handshake; pulse_valid is 0 in the cycle after rst.
- Throughput: a NOP or JUMP costs 2 cycles (FETCH + EXEC).

Decomposition:
- Package readout_tx_pkg: opcode localparams (OP_NOP..OP_HALT), field bit positions, state encoding.
- One natural sub-module, readout_tx_seq_decode: combinational op/imm/tgt split plus legal-opcode flag.
- The existing PC register stays external and is driven directly by update_pc / next_pc.

Test Plan:
- start_pc=0x010, NOP at 0x010 and HALT at 0x011 → update_pc strobes next_pc=0x010 then 0x011; halted=1 four cycles after start; busy=0 afterwards.
- PLAY imm=0x0025 with pulse_ready low 3 cycles then high → pulse_valid high 4 cycles with pulse_id=0x0025 stable; update_pc=1 exactly in the ready cycle.
- WAIT imm=5 → exactly 5 cycles in WAIT, then update_pc with next_pc=pc+1; WAIT imm=0 → behaves as NOP (2 cycles).
- Body PLAY at 0x020, LOOP imm=2 tgt=0x020 at 0x021 → 3 accepted pulses, then execution continues at 0x022; a second entry to the LOOP re-arms the count.
- JUMP at pc=0x7FF with NOP at 0x7FF/wrap → pc+1 gives 0x000; opcode 0xF → error=1, halted=1; a following start clears error.
- stop during PLAY with pulse_ready low → pulse_valid=0 and IDLE next cycle, no update_pc; rst during WAIT gives all outputs at reset values.
